// File: rtl/dec_seq_n.sv
// Registered AW-to-2^AW one-hot strobe decoder with direct-load and scan sequencer modes.
// Optional DEC_SEQ_AUTOREP_EN: cyclic auto-repeat scan with an added stop input.
module dec_seq_n #(
  parameter int AW = 3
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 gn,
  input  logic                 mode,
  input  logic                 load,
  input  logic [AW-1:0]        a,
  input  logic                 start,
  input  logic                 step,
  input  logic [AW-1:0]        last,
`ifdef DEC_SEQ_AUTOREP_EN
  input  logic                 stop,
`endif
  output logic [(1<<AW)-1:0]   z,
  output logic [AW-1:0]        cur,
  output logic                 busy,
  output logic                 done
);

  localparam int N = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_q, cur_d;
  logic [AW-1:0]   last_r_q, last_r_d;
  logic [N-1:0]    z_q, z_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef DEC_SEQ_AUTOREP_EN
  logic [AW-1:0]   start_r_q, start_r_d;
`endif

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_r_d = last_r_q;
    z_d      = '0;
    done_d   = 1'b0;
`ifdef DEC_SEQ_AUTOREP_EN
    start_r_d = start_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (!mode) begin
          if (load) cur_d = a;
          z_d = onehot(cur_d) & {N{~gn}};
        end else if (start) begin
          cur_d    = a;
          last_r_d = last;
`ifdef DEC_SEQ_AUTOREP_EN
          start_r_d = a;
`endif
          state_d  = RUN;
          z_d      = onehot(a) & {N{~gn}};
        end
      end
      RUN: begin
`ifdef DEC_SEQ_AUTOREP_EN
        if (stop) begin
          state_d = FIN;
        end else if (step) begin
          if (cur_q != last_r_q) begin
            cur_d = cur_q + AW'(1);
          end else begin
            cur_d  = start_r_q;
            done_d = 1'b1;
          end
        end
`else
        if (step) begin
          if (cur_q != last_r_q) cur_d = cur_q + AW'(1);
          else                   state_d = FIN;
        end
`endif
        // z tracks the index that will be current after this edge
        if (state_d == RUN) z_d = onehot(cur_d) & {N{~gn}};
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    if (state_d == FIN) done_d = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_r_q <= '0;
      z_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DEC_SEQ_AUTOREP_EN
      start_r_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_r_q <= last_r_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DEC_SEQ_AUTOREP_EN
      start_r_q <= start_r_d;
`endif
    end
  end

  assign z    = z_q;
  assign cur  = cur_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
